// File: rtl/fetch_unit_if.sv
// Fetch-to-decode and fetch-to-instruction-BRAM signal bundle.
// The fetch unit uses the slave view; the decode/BRAM side uses master.
interface fetch_unit_if #(
   parameter int INST_SIZE = 10
);
   logic                 start;
   logic                 stall;
   logic                 redirect_valid;
   logic [31:0]          redirect_pc;
   logic                 halt;
   logic [INST_SIZE-1:0] imem_addr;
   logic [31:0]          imem_rdata;
   logic [31:0]          pc;
   logic [31:0]          inst;
   logic                 valid;
   logic                 running;
   logic [31:0]          issue_count;

   modport slave (
      input  start, stall, redirect_valid, redirect_pc, halt, imem_rdata,
      output imem_addr, pc, inst, valid, running, issue_count
   );

   modport master (
      output start, stall, redirect_valid, redirect_pc, halt, imem_rdata,
      input  imem_addr, pc, inst, valid, running, issue_count
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, addresses a 1-cycle-latency BRAM and presents
// pc/inst to decode with stall hold, redirect squash and halt on stop.
module fetch_unit #(
   parameter int          INST_SIZE = 10,
   parameter logic [31:0] RESET_PC  = 32'h0
) (
   input logic         clk,
   input logic         rstn,
   fetch_unit_if.slave bus
);
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_HALT = 2'd2
   } state_t;

   state_t      r_state,       w_state_nx;
   logic [31:0] r_fpc,         w_fpc_nx;
   logic [31:0] r_dpc,         w_dpc_nx;
   logic        r_dvalid,      w_dvalid_nx;
   logic [31:0] r_hold_inst,   w_hold_inst_nx;
   logic        r_hold_valid,  w_hold_valid_nx;
   logic [31:0] r_issue_cnt,   w_issue_cnt_nx;
   logic [31:0] w_redir_tgt;

   assign w_redir_tgt = bus.redirect_pc & ~32'h3;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state      <= S_IDLE;
         r_fpc        <= RESET_PC;
         r_dpc        <= RESET_PC;
         r_dvalid     <= 1'b0;
         r_hold_inst  <= 32'h0;
         r_hold_valid <= 1'b0;
         r_issue_cnt  <= 32'h0;
      end else begin
         r_state      <= w_state_nx;
         r_fpc        <= w_fpc_nx;
         r_dpc        <= w_dpc_nx;
         r_dvalid     <= w_dvalid_nx;
         r_hold_inst  <= w_hold_inst_nx;
         r_hold_valid <= w_hold_valid_nx;
         r_issue_cnt  <= w_issue_cnt_nx;
      end
   end

   always_comb begin
      w_state_nx      = r_state;
      w_fpc_nx        = r_fpc;
      w_dpc_nx        = r_dpc;
      w_dvalid_nx     = r_dvalid;
      w_hold_inst_nx  = r_hold_inst;
      w_hold_valid_nx = r_hold_valid;
      w_issue_cnt_nx  = r_issue_cnt;
      case (r_state)
         S_IDLE: begin
            w_dvalid_nx = 1'b0;
            if (bus.start) begin
               w_fpc_nx   = RESET_PC;
               w_state_nx = S_RUN;
            end
         end
         S_RUN: begin
            // Redirect outranks everything: the presented word is squashed uncounted.
            if (bus.redirect_valid) begin
               w_fpc_nx        = w_redir_tgt;
               w_dvalid_nx     = 1'b0;
               w_hold_valid_nx = 1'b0;
            end else if (bus.halt && r_dvalid && !bus.stall) begin
               w_issue_cnt_nx = r_issue_cnt + 32'd1;
               w_dvalid_nx    = 1'b0;
               w_state_nx     = S_HALT;
            end else if (bus.stall) begin
               // BRAM keeps reading fpc, so freeze the presented word locally.
               if (!r_hold_valid && r_dvalid) begin
                  w_hold_inst_nx  = bus.imem_rdata;
                  w_hold_valid_nx = 1'b1;
               end
            end else begin
               w_dpc_nx        = r_fpc;
               w_dvalid_nx     = 1'b1;
               w_fpc_nx        = r_fpc + 32'd4;
               w_hold_valid_nx = 1'b0;
               if (r_dvalid) begin
                  w_issue_cnt_nx = r_issue_cnt + 32'd1;
               end
            end
         end
         S_HALT: begin
            w_dvalid_nx = 1'b0;
         end
         default: begin
            w_state_nx = S_IDLE;
         end
      endcase
   end

   assign bus.imem_addr   = r_fpc[INST_SIZE+1:2];
   assign bus.pc          = r_dpc;
   assign bus.valid       = r_dvalid;
   assign bus.inst        = r_hold_valid ? r_hold_inst : (r_dvalid ? bus.imem_rdata : 32'h0);
   assign bus.running     = (r_state == S_RUN);
   assign bus.issue_count = r_issue_cnt;
endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit: a program-order reference model
// predicts the presented instruction each cycle; a monitor compares.
module tb_fetch_unit;
   localparam int          INST_SIZE = 10;
   localparam logic [31:0] RESET_PC  = 32'h0;

   logic clk;
   logic rstn;
   fetch_unit_if #(.INST_SIZE(INST_SIZE)) bus ();

   fetch_unit #(.INST_SIZE(INST_SIZE), .RESET_PC(RESET_PC)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] mem [0:(1<<INST_SIZE)-1];
   always @(posedge clk) bus.imem_rdata <= mem[bus.imem_addr];

   typedef struct {
      logic [31:0]          pc;
      logic [31:0]          inst;
      logic                 chk_inst;
      logic                 valid;
      logic                 running;
      logic [31:0]          cnt;
      logic [INST_SIZE-1:0] addr;
   } exp_t;

   exp_t q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // Reference model: program-order view of what decode should be shown.
   int          m_st;     // 0 idle, 1 run, 2 halted
   logic [31:0] m_pc;     // pc of presented instruction
   logic [31:0] m_next;   // pc of the next instruction in program order
   logic        m_valid;
   logic [31:0] m_cnt;

   function automatic int unsigned widx(input logic [31:0] a);
      return int'(a[INST_SIZE+1:2]);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_st = 0; m_pc = RESET_PC; m_next = RESET_PC; m_valid = 1'b0; m_cnt = 32'h0;
   endtask

   task automatic model_step(input bit st, input bit sl, input bit rv,
                             input logic [31:0] rp, input bit hl);
      if (m_st == 0) begin
         if (st) begin m_next = RESET_PC; m_st = 1; end
      end else if (m_st == 1) begin
         if (rv) begin
            m_valid = 1'b0;
            m_next  = rp & ~32'h3;
         end else if (hl && m_valid && !sl) begin
            m_cnt   = m_cnt + 1;
            m_valid = 1'b0;
            m_st    = 2;
         end else if (!sl) begin
            if (m_valid) m_cnt = m_cnt + 1;
            m_pc    = m_next;
            m_next  = m_next + 4;
            m_valid = 1'b1;
         end
      end
   endtask

   task automatic cyc(input bit st, input bit sl, input bit rv,
                      input logic [31:0] rp, input bit hl);
      exp_t e;
      @(negedge clk);
      bus.start = st; bus.stall = sl; bus.redirect_valid = rv;
      bus.redirect_pc = rp; bus.halt = hl;
      model_step(st, sl, rv, rp, hl);
      e.pc       = m_pc;
      e.valid    = m_valid;
      e.inst     = m_valid ? mem[widx(m_pc)] : 32'h0;
      e.chk_inst = (m_st != 2);
      e.running  = (m_st == 1);
      e.cnt      = m_cnt;
      e.addr     = m_next[INST_SIZE+1:2];
      q.push_back(e);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_pc"},      bus.pc, RESET_PC);
      chk({tag, "_inst"},    bus.inst, 32'h0);
      chk({tag, "_valid"},   {31'h0, bus.valid}, 32'h0);
      chk({tag, "_running"}, {31'h0, bus.running}, 32'h0);
      chk({tag, "_count"},   bus.issue_count, 32'h0);
      chk({tag, "_addr"},    {22'h0, bus.imem_addr}, {22'h0, RESET_PC[INST_SIZE+1:2]});
   endtask

   // Monitor: one expected entry per cycle, compared just after the edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("pc",      bus.pc, e.pc);
            chk("valid",   {31'h0, bus.valid}, {31'h0, e.valid});
            chk("running", {31'h0, bus.running}, {31'h0, e.running});
            chk("count",   bus.issue_count, e.cnt);
            chk("addr",    {22'h0, bus.imem_addr}, {22'h0, e.addr});
            if (e.chk_inst) chk("inst", bus.inst, e.inst);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < (1 << INST_SIZE); i++) mem[i] = $urandom;
      bus.start = 1'b0; bus.stall = 1'b0; bus.redirect_valid = 1'b0;
      bus.redirect_pc = 32'h0; bus.halt = 1'b0;
      rstn = 1'b1;
      #2 rstn = 1'b0;
      model_reset();
      #1;
      chk_reset_outputs("rst");
      repeat (2) @(negedge clk);
      rstn = 1'b1;

      cyc(0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0);                       // start
      cyc(0, 0, 0, 0, 0);                       // pc=0
      cyc(0, 0, 0, 0, 0);                       // pc=4
      repeat (3) cyc(0, 1, 0, 0, 0);            // stall holding pc=4
      cyc(0, 0, 0, 0, 0);                       // pc=8
      cyc(0, 0, 1, 32'h103, 0);                 // squash pc=8
      cyc(0, 0, 0, 0, 0);                       // pc=0x100
      repeat (2) cyc(0, 0, 0, 0, 0);
      cyc(0, 1, 1, 32'h200, 0);                 // redirect beats stall
      repeat (2) cyc(0, 0, 0, 0, 0);
      repeat (2) cyc(0, 1, 0, 0, 0);
      cyc(0, 1, 1, 32'h302, 0);                 // clears an active hold
      repeat (2) cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 1, 32'hFFFF_FFF8, 0);           // fpc wraps past 2^32
      repeat (4) cyc(0, 0, 0, 0, 0);

      for (int i = 0; i < 300; i++)
         cyc(0, $urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0, $urandom, 0);

      repeat (2) cyc(0, 0, 0, 0, 0);
      repeat (2) cyc(0, 1, 0, 0, 1);            // halt waits for stall release
      cyc(0, 0, 0, 0, 1);                       // stop counted, enter HALT
      for (int i = 0; i < 20; i++)
         cyc($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
             $urandom, $urandom_range(0, 1));

      // Async reset from halted state, then restart and run.
      @(posedge clk);
      #3 rstn = 1'b0;
      model_reset();
      #1;
      chk_reset_outputs("arst_halt");
      @(negedge clk);
      rstn = 1'b1;
      repeat (3) cyc(0, $urandom_range(0, 1), $urandom_range(0, 1), $urandom, 0);
      cyc(1, 0, 0, 0, 0);
      for (int i = 0; i < 40; i++)
         cyc(0, $urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0, $urandom, 0);

      // Async reset mid-run, between edges.
      @(posedge clk);
      #3 rstn = 1'b0;
      model_reset();
      #1;
      chk_reset_outputs("arst_run");
      @(negedge clk);
      rstn = 1'b1;
      repeat (3) cyc(0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0);
      for (int i = 0; i < 60; i++)
         cyc(0, $urandom_range(0, 9) < 3, $urandom_range(0, 24) == 0, $urandom, 0);

      @(posedge clk);
      #4;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
